// File: rtl/rr_onehot_arbiter.sv
// Round-robin arbiter producing a registered one-hot (or all-zero) grant for a one-hot mux select.
// Rotating priority pointer gives fairness; a hold limit bounds how long one holder can block others.
module rr_onehot_arbiter #(
  parameter  int NUM_REQ  = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic               gnt_valid_o,
  output logic [IDX_W-1:0]   gnt_idx_o
);

  localparam int HOLD_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic                 valid_q;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;

  logic [NUM_REQ-1:0]   others;
  logic                 holder_req;
  logic                 grant_new;
  logic [NUM_REQ-1:0]   pick_vec;
  logic [IDX_W-1:0]     winner;

  // First asserted bit of vec, searching upward from last+1 with wrap-around.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] vec,
                                               input logic [IDX_W-1:0]   last);
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] sel;
    logic             found;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      sel = IDX_W'((int'(last) + k) % NUM_REQ);
      if (!found && vec[sel]) begin
        win   = sel;
        found = 1'b1;
      end
    end
    return win;
  endfunction

  // gnt_q is one-hot of the holder, so masking with it removes exactly the holder.
  assign others     = req_i & ~gnt_q;
  assign holder_req = |(req_i & gnt_q);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    last_d    = last_q;
    hold_d    = hold_q;
    grant_new = 1'b0;
    pick_vec  = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_new = 1'b1;
          pick_vec  = req_i;
        end
      end
      GRANT: begin
        if (!holder_req) begin
          if (|others) begin
            grant_new = 1'b1;
            pick_vec  = others;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
          end
        end else if (|others && hold_q == HOLD_MAX) begin
          grant_new = 1'b1;
          pick_vec  = others;
        end else if (hold_q != HOLD_MAX) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    winner = rr_pick(pick_vec, last_q);
    if (grant_new) begin
      state_d = GRANT;
      gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << winner;
      idx_d   = winner;
      last_d  = winner;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
      last_q  <= IDX_W'(NUM_REQ - 1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      valid_q <= |gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = valid_q;
  assign gnt_idx_o   = idx_q;

  a_onehot : assert property (@(posedge clk) $onehot0(gnt_o));
  a_valid  : assert property (@(posedge clk) gnt_valid_o == (|gnt_o));
  a_idx_on : assert property (@(posedge clk) gnt_valid_o |-> gnt_o[gnt_idx_o]);
  a_idx_off: assert property (@(posedge clk) !gnt_valid_o |-> gnt_idx_o == '0);

endmodule

// File: tb/tb_rr_onehot_arbiter.sv
// Self-checking bench for rr_onehot_arbiter: directed scenarios plus random traffic
// compared against an integer-level round-robin model with a starvation-bound check.
module tb_rr_onehot_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;
  localparam int IW = 2;
  localparam int STARVE_MAX = (N - 1) * MH;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_i;
  logic [N-1:0]  gnt_o;
  logic          gnt_valid_o;
  logic [IW-1:0] gnt_idx_o;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Model state: holder index (-1 = none), priority pointer, cycles held since grant.
  int m_holder;
  int m_last;
  int m_cnt;

  rr_onehot_arbiter #(.NUM_REQ(N), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .gnt_o      (gnt_o),
    .gnt_valid_o(gnt_valid_o),
    .gnt_idx_o  (gnt_idx_o)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last + k) % N;
      if (v[IW'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    return (i < 0) ? '0 : (N'(1) << i);
  endfunction

  function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic model_step(input logic [N-1:0] r, input logic rst);
    logic [N-1:0] others;
    if (rst) begin
      m_holder = -1;
      m_last   = N - 1;
      m_cnt    = 0;
    end else if (m_holder < 0) begin
      if (r != 0) begin
        m_holder = pick(r, m_last);
        m_last   = m_holder;
        m_cnt    = 0;
      end
    end else begin
      others = r & ~onehot(m_holder);
      if (!r[IW'(m_holder)] || (others != 0 && m_cnt == MH - 1)) begin
        m_holder = (others != 0) ? pick(others, m_last) : -1;
        if (m_holder >= 0) m_last = m_holder;
        m_cnt = 0;
      end else if (m_cnt < MH - 1) begin
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic step(input logic [N-1:0] r, input logic rst);
    reset = rst;
    req_i = r;
    model_step(r, rst);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] e;
    e = '0;
    step('0, 1'b1);
    step('0, 1'b1);
    vec_cnt++;
    if (gnt_o !== e || gnt_valid_o !== 1'b0 || gnt_idx_o !== '0) begin
      err_cnt++;
      $display("FAIL reset_state: got gnt=%b valid=%b idx=%0d, want gnt=%b valid=0 idx=0",
               gnt_o, gnt_valid_o, gnt_idx_o, e);
    end
    for (int c = 0; c < 5; c++) begin
      step('0, 1'b0);
      vec_cnt++;
      if (gnt_o !== e || gnt_valid_o !== 1'b0 || gnt_idx_o !== '0) begin
        err_cnt++;
        $display("FAIL idle_no_req c%0d: got gnt=%b valid=%b idx=%0d, want gnt=%b valid=0 idx=0",
                 c, gnt_o, gnt_valid_o, gnt_idx_o, e);
      end
    end
  endtask

  task automatic test_all_req();
    logic [N-1:0] e;
    step('0, 1'b1);
    for (int k = 0; k < 20; k++) begin
      step(4'b1111, 1'b0);
      e = onehot((k / MH) % N);
      vec_cnt++;
      if (gnt_o !== e || gnt_valid_o !== 1'b1 || gnt_idx_o !== idx_of(e)) begin
        err_cnt++;
        $display("FAIL all_req cyc%0d: got gnt=%b valid=%b idx=%0d, want gnt=%b valid=1 idx=%0d",
                 k + 1, gnt_o, gnt_valid_o, gnt_idx_o, e, idx_of(e));
      end
    end
  endtask

  task automatic test_alone();
    logic [N-1:0] e;
    step('0, 1'b1);
    e = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      step(4'b0100, 1'b0);
      vec_cnt++;
      if (gnt_o !== e || gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd2) begin
        err_cnt++;
        $display("FAIL alone cyc%0d: got gnt=%b valid=%b idx=%0d, want gnt=%b valid=1 idx=2",
                 k + 1, gnt_o, gnt_valid_o, gnt_idx_o, e);
      end
    end
    step('0, 1'b0);
    vec_cnt++;
    if (gnt_o !== '0 || gnt_valid_o !== 1'b0 || gnt_idx_o !== '0) begin
      err_cnt++;
      $display("FAIL alone_drop: got gnt=%b valid=%b idx=%0d, want gnt=0000 valid=0 idx=0",
               gnt_o, gnt_valid_o, gnt_idx_o);
    end
  endtask

  task automatic test_holder_drop_and_wrap();
    step('0, 1'b1);
    step(4'b1010, 1'b0);
    step(4'b1010, 1'b0);
    vec_cnt++;
    if (gnt_o !== 4'b0010 || gnt_idx_o !== 2'd1) begin
      err_cnt++;
      $display("FAIL drop_pre: got gnt=%b idx=%0d, want gnt=0010 idx=1", gnt_o, gnt_idx_o);
    end
    step(4'b1000, 1'b0);
    vec_cnt++;
    if (gnt_o !== 4'b1000 || gnt_valid_o !== 1'b1 || gnt_idx_o !== 2'd3) begin
      err_cnt++;
      $display("FAIL drop_handover: got gnt=%b valid=%b idx=%0d, want gnt=1000 valid=1 idx=3",
               gnt_o, gnt_valid_o, gnt_idx_o);
    end
    step(4'b0000, 1'b0);
    vec_cnt++;
    if (gnt_o !== 4'b0000 || gnt_valid_o !== 1'b0) begin
      err_cnt++;
      $display("FAIL wrap_idle: got gnt=%b valid=%b, want gnt=0000 valid=0", gnt_o, gnt_valid_o);
    end
    step(4'b1001, 1'b0);
    vec_cnt++;
    if (gnt_o !== 4'b0001 || gnt_idx_o !== 2'd0) begin
      err_cnt++;
      $display("FAIL wrap_pick: got gnt=%b idx=%0d, want gnt=0001 idx=0", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_reset_mid_grant();
    step('0, 1'b1);
    for (int k = 0; k < MH + 1; k++) step(4'b1111, 1'b0);
    vec_cnt++;
    if (gnt_o !== 4'b0010) begin
      err_cnt++;
      $display("FAIL rst_mid_pre: got gnt=%b, want gnt=0010", gnt_o);
    end
    step(4'b1111, 1'b1);
    vec_cnt++;
    if (gnt_o !== '0 || gnt_valid_o !== 1'b0 || gnt_idx_o !== '0) begin
      err_cnt++;
      $display("FAIL rst_mid_drop: got gnt=%b valid=%b idx=%0d, want gnt=0000 valid=0 idx=0",
               gnt_o, gnt_valid_o, gnt_idx_o);
    end
    step(4'b1111, 1'b0);
    vec_cnt++;
    if (gnt_o !== 4'b0001 || gnt_idx_o !== 2'd0) begin
      err_cnt++;
      $display("FAIL rst_mid_regrant: got gnt=%b idx=%0d, want gnt=0001 idx=0", gnt_o, gnt_idx_o);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] e;
    logic         rst;
    int           wait_cnt [N];
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    r = '0;
    step('0, 1'b1);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(7) == 0) r[i] = ~r[i];
      rst = ($urandom_range(299) == 0);
      step(r, rst);
      e = onehot(m_holder);
      vec_cnt++;
      if (gnt_o !== e || gnt_valid_o !== (e != 0) || gnt_idx_o !== idx_of(e)) begin
        err_cnt++;
        $display("FAIL random cyc%0d req=%b: got gnt=%b valid=%b idx=%0d, want gnt=%b valid=%b idx=%0d",
                 c, r, gnt_o, gnt_valid_o, gnt_idx_o, e, (e != 0), idx_of(e));
      end
      for (int i = 0; i < N; i++) begin
        if (rst || !r[i] || gnt_o[i] === 1'b1) wait_cnt[i] = 0;
        else wait_cnt[i] = wait_cnt[i] + 1;
        vec_cnt++;
        if (wait_cnt[i] > STARVE_MAX) begin
          err_cnt++;
          $display("FAIL starvation cyc%0d req%0d: waited %0d cycles, limit %0d",
                   c, i, wait_cnt[i], STARVE_MAX);
          wait_cnt[i] = 0;
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    req_i = '0;
    m_holder = -1;
    m_last   = N - 1;
    m_cnt    = 0;
    test_reset();
    test_all_req();
    test_alone();
    test_holder_drop_and_wrap();
    test_reset_mid_grant();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
